control_buffer_filas: RTL

- Sequencer for a row delay line built from N_UNIDADES buffer units, each a PROF_UNIDAD-deep FIFO gated by its own enable.
- Takes an incoming pixel stream for an image of programmable width and height. Column c of every row is written to unit floor(c/PROF_UNIDAD).
- From the second row on, it reads the same column of the previous row from that unit in the same cycle, so the unit bank acts as a delay of exactly one row.
- Sits between the pixel source and the window/filter datapath. It drives unit enables, read_req, write_req and the unit sclr, and tells the datapath when the previous-row pixel is valid and which unit output to select.

---
 rtl/control_buffer_filas_pkg.sv | 12 +
 rtl/control_buffer_filas_if.sv | 35 +++
 rtl/control_buffer_filas_contador.sv | 33 +++
 rtl/control_buffer_filas.sv | 68 ++++++
 4 files changed

// File: rtl/control_buffer_filas_pkg.sv
// Shared constants and FSM encoding for the row delay line sequencer.
package control_buffer_filas_pkg;
  localparam int N_UNIDADES  = 16;
  localparam int PROF_UNIDAD = 8;
  localparam int ANCHO_W     = 8;
  localparam int ALTO_W      = 10;
  localparam int SEL_W       = $clog2(N_UNIDADES);
  localparam int MAX_ANCHO   = N_UNIDADES * PROF_UNIDAD;
  localparam int LOG2_PROF   = $clog2(PROF_UNIDAD);

  typedef enum logic [1:0] {IDLE, LLENADO, FLUJO, FIN} estado_t;
endpackage

// File: rtl/control_buffer_filas_if.sv
// Pixel-source / buffer-bank / datapath signals of the row delay sequencer.
interface control_buffer_filas_if
  import control_buffer_filas_pkg::*;
  ();
  logic                  inicio;
  logic [ANCHO_W-1:0]    ancho;
  logic [ALTO_W-1:0]     alto;
  logic                  pixel_valido;
  logic                  listo;
  logic [N_UNIDADES-1:0] enable_unidades;
  logic                  write_req;
  logic                  read_req;
  logic                  sclr_buffers;
  logic [SEL_W-1:0]      sel_unidad;
  logic                  dato_fila_valido;
  logic [ANCHO_W-1:0]    columna;
  logic [ALTO_W-1:0]     fila;
  logic                  ocupado;
  logic                  fin;
  logic                  error_cfg;

  // Controller side
  modport slave (
    input  inicio, ancho, alto, pixel_valido,
    output listo, enable_unidades, write_req, read_req, sclr_buffers,
           sel_unidad, dato_fila_valido, columna, fila, ocupado, fin, error_cfg
  );

  // Source / system side
  modport master (
    output inicio, ancho, alto, pixel_valido,
    input  listo, enable_unidades, write_req, read_req, sclr_buffers,
           sel_unidad, dato_fila_valido, columna, fila, ocupado, fin, error_cfg
  );
endinterface

// File: rtl/control_buffer_filas_contador.sv
// Column/row position counter; columna wraps at ancho-1 and advances fila.
module contador_columna_fila
  import control_buffer_filas_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [ANCHO_W-1:0] ancho,
  input  logic [ALTO_W-1:0]  alto,
  output logic [ANCHO_W-1:0] columna,
  output logic [ALTO_W-1:0]  fila,
  output logic               fin_fila,
  output logic               ultimo
);
  assign fin_fila = (columna == ancho - ANCHO_W'(1));
  assign ultimo   = fin_fila && (fila == alto - ALTO_W'(1));

  // Advance one position per accepted pixel
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      columna <= '0;
      fila    <= '0;
    end else if (en) begin
      if (fin_fila) begin
        columna <= '0;
        fila    <= fila + ALTO_W'(1);
      end else begin
        columna <= columna + ANCHO_W'(1);
      end
    end
  end
endmodule

// File: rtl/control_buffer_filas.sv
// Sequencer for a one-row delay line made of N_UNIDADES FIFO units.
module control_buffer_filas
  import control_buffer_filas_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  control_buffer_filas_if.slave  bus
);
  localparam logic [ANCHO_W:0] MAX_ANCHO_V = (ANCHO_W+1)'(MAX_ANCHO);

  estado_t            estado;
  logic [ANCHO_W-1:0] ancho_q;
  logic [ALTO_W-1:0]  alto_q;
  logic               acc, rd, cfg_ok, arranque, fin_fila, ultimo;
  logic [SEL_W-1:0]   unidad;

  assign cfg_ok   = (bus.ancho != '0) && ({1'b0, bus.ancho} <= MAX_ANCHO_V) && (bus.alto != '0);
  assign arranque = (estado == IDLE) && bus.inicio && cfg_ok;
  assign acc      = bus.pixel_valido && bus.listo;
  assign rd       = acc && (estado == FLUJO);
  assign unidad   = SEL_W'(bus.columna >> LOG2_PROF);

  assign bus.listo           = (estado == LLENADO) || (estado == FLUJO);
  assign bus.write_req       = acc;
  assign bus.read_req        = rd;
  assign bus.enable_unidades = acc ? (N_UNIDADES'(1) << unidad) : '0;
  assign bus.sclr_buffers    = arranque || (estado == FIN);
  assign bus.error_cfg       = (estado == IDLE) && bus.inicio && !cfg_ok;
  assign bus.ocupado         = (estado != IDLE);
  assign bus.fin             = (estado == FIN);

  contador_columna_fila u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (arranque),
    .en       (acc),
    .ancho    (ancho_q),
    .alto     (alto_q),
    .columna  (bus.columna),
    .fila     (bus.fila),
    .fin_fila (fin_fila),
    .ultimo   (ultimo)
  );

  // Frame FSM plus the one-cycle read-latency alignment of valid/select
  always_ff @(posedge clk) begin
    if (reset) begin
      estado               <= IDLE;
      ancho_q              <= '0;
      alto_q               <= '0;
      bus.dato_fila_valido <= 1'b0;
      bus.sel_unidad       <= '0;
    end else begin
      bus.dato_fila_valido <= rd;
      if (rd) bus.sel_unidad <= unidad;
      case (estado)
        IDLE: if (arranque) begin
          ancho_q <= bus.ancho;
          alto_q  <= bus.alto;
          estado  <= LLENADO;
        end
        LLENADO: if (acc && fin_fila) estado <= (alto_q == ALTO_W'(1)) ? FIN : FLUJO;
        FLUJO:   if (acc && ultimo) estado <= FIN;
        default: estado <= IDLE;
      endcase
    end
  end
endmodule
